key_conditioner: RTL and testbench



---
 rtl/ddr_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 115 +++++++++++
 rtl/key_conditioner.sv | 49 ++++
 tb/tb_key_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR game front-end: clock rate, debounce
// interval and the per-key debounce state encoding.
package ddr_pkg;

  localparam int CLOCK_50MHZ   = 50_000_000;
  // 20 ms worth of 50 MHz cycles (1_000_000).
  localparam int DEBOUNCE_20MS = CLOCK_50MHZ / 50;

  // Bit 1 of the encoding is the debounced "held" level.
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } key_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce counter and press/release FSM.
// press_next is the value press takes on the coming edge, so the top level
// can register its own derived outputs in step with press.
module key_debounce_ch
  import ddr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic held,
  output logic press,
  output logic press_next,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  key_state_t             state;
  key_state_t             state_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   release_next;

  assign s = sync[SYNC_STAGES-1];

  // Shift the raw active-low key through the synchroniser; reset reads as released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_n};
    end
  end

  // State, counter and registered pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      press         <= press_next;
      release_pulse <= release_next;
    end
  end

  // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronised samples at the new level; any sample back at the
  // old level aborts the wait without a pulse.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      RELEASED: begin
        if (!s) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = RELEASED;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  assign held = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/key_conditioner.sv
// Conditions the DE-board push-buttons into debounced levels, press/release
// pulses and an active-low press strobe for the game controller.
module key_conditioner
  import ddr_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_strobe_n,
  output logic                any_press
);

  logic [NUM_KEYS-1:0] press_next;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .key_n        (key_n[k]),
      .held         (key_held[k]),
      .press        (key_press[k]),
      .press_next   (press_next[k]),
      .release_pulse(key_release[k])
    );
  end

  // Strobe and any-press are registered from the same next value as key_press
  // so all three line up on the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_strobe_n <= '1;
      any_press    <= 1'b0;
    end else begin
      key_strobe_n <= ~press_next;
      any_press    <= |press_next;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner with a run-length
// reference model and a scoreboard queue.
module tb_key_conditioner;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_held, key_press, key_release, key_strobe_n;
  logic          any_press;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_n       (key_n),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .key_strobe_n(key_strobe_n),
    .any_press   (any_press)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NK-1:0] held;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] strobe_n;
    logic          any;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   press_count[NK];
  int   release_count[NK];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: the key level flips once DEB consecutive synchronised
  // samples disagree with the current accepted level.
  logic [NK-1:0] delay_line[SYNC];
  logic [NK-1:0] level;
  int            run[NK];

  always @(posedge clock) begin
    exp_t          e;
    logic [NK-1:0] s;
    e.held = '0; e.press = '0; e.rel = '0; e.strobe_n = '1; e.any = 1'b0;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) delay_line[i] = '1;
      level = '0;
      for (int k = 0; k < NK; k++) run[k] = 0;
    end else begin
      s = delay_line[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) delay_line[i] = delay_line[i-1];
      delay_line[0] = key_n;
      for (int k = 0; k < NK; k++) begin
        if (!s[k] != level[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == DEB) begin
          run[k] = 0;
          level[k] = ~level[k];
          if (level[k]) e.press[k] = 1'b1;
          else e.rel[k] = 1'b1;
        end
      end
      e.held = level;
      e.strobe_n = ~e.press;
      e.any = |e.press;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare the DUT against the oldest expectation, away from the edge.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("key_held", 32'(key_held), 32'(e.held));
      check_output("key_press", 32'(key_press), 32'(e.press));
      check_output("key_release", 32'(key_release), 32'(e.rel));
      check_output("key_strobe_n", 32'(key_strobe_n), 32'(e.strobe_n));
      check_output("any_press", 32'(any_press), 32'(e.any));
      for (int k = 0; k < NK; k++) begin
        if (key_press[k]) press_count[k]++;
        if (key_release[k]) release_count[k]++;
      end
    end
  end

  task automatic apply_stimulus(input logic [NK-1:0] kn, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      #1 key_n = kn;
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clock);
    #1 reset = 1'b1;
    repeat (cycles) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            p0;
    int            r0;
    logic [NK-1:0] cur;
    for (int k = 0; k < NK; k++) begin
      press_count[k] = 0;
      release_count[k] = 0;
    end
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    apply_stimulus(4'b1111, 5);

    // Clean press of key 1, held for over 100 cycles.
    p0 = press_count[1];
    apply_stimulus(4'b1101, 110);
    check_output("clean_press_count", 32'(press_count[1] - p0), 32'd1);
    apply_stimulus(4'b1111, 12);

    // Bounce on key 0, then stable low, then release.
    p0 = press_count[0];
    r0 = release_count[0];
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'b1110, 2);
      apply_stimulus(4'b1111, 2);
    end
    apply_stimulus(4'b1110, 12);
    check_output("bounce_press_count", 32'(press_count[0] - p0), 32'd1);
    check_output("bounce_release_count", 32'(release_count[0] - r0), 32'd0);
    apply_stimulus(4'b1111, 12);
    check_output("release_count", 32'(release_count[0] - r0), 32'd1);

    // All keys at once.
    apply_stimulus(4'b0000, 12);
    apply_stimulus(4'b1111, 12);

    // Reset while key 0 is in its debounce wait, key kept low throughout.
    p0 = press_count[0];
    apply_stimulus(4'b1110, 4);
    pulse_reset(2);
    check_output("reset_wait_no_pulse", 32'(press_count[0] - p0), 32'd0);
    apply_stimulus(4'b1110, 10);
    check_output("reset_wait_fresh_press", 32'(press_count[0] - p0), 32'd1);

    // Reset while pressed: held drops, no release pulse.
    r0 = release_count[0];
    pulse_reset(2);
    check_output("reset_pressed_held", 32'(key_held[0]), 32'd0);
    check_output("reset_pressed_no_release", 32'(release_count[0] - r0), 32'd0);
    apply_stimulus(4'b1111, 12);

    // Short glitch on key 2.
    p0 = press_count[2];
    apply_stimulus(4'b1011, 3);
    apply_stimulus(4'b1111, 12);
    check_output("glitch_press_count", 32'(press_count[2] - p0), 32'd0);

    // Random key activity with occasional resets.
    cur = '1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int idx;
        idx = int'($urandom_range(0, NK-1));
        cur[idx] = ~cur[idx];
      end
      if ($urandom_range(0, 249) == 0) pulse_reset(1);
      apply_stimulus(cur, 1);
    end
    apply_stimulus(4'b1111, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
